// File: rtl/latency_pkg.sv
// Shared constants and the elaboration-time latency range check for the
// per-port request-delay stage.
package latency_pkg;

    localparam int MAX_LATENCY = 16;

    // True when a configured latency fits the supported 1..MAX_LATENCY range.
    function automatic bit latency_ok(input int lat);
        return (lat >= 1) && (lat <= MAX_LATENCY);
    endfunction

endpackage

// File: rtl/delay_line.sv
// Synchronous-reset shift register chain: DEPTH stages of WIDTH bits.
// The output is the last stage, so a value entering at edge N appears
// after edge N+DEPTH-1.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clka,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "delay_line: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    // Shift one stage per cycle; reset clears every stage so in-flight values are dropped.
    always_ff @(posedge clka) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/port_latency_stage.sv
// Per-port request-delay stage in front of a dual-port memory. Write and read
// bundles travel through independent delay chains; a tag chain one stage
// longer than the read chain marks when the memory's registered read data is
// valid. Same-address write/read meeting at the memory is flagged, not stalled.
module port_latency_stage
    import latency_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int WR_LATENCY = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic                  i_rd,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_en_wr,
    output logic                  o_we,
    output logic [DATA_WIDTH-1:0] o_din,
    output logic [ADDR_WIDTH-1:0] o_addr_wr,
    output logic                  o_en_rd,
    output logic                  o_rd_n,
    output logic [ADDR_WIDTH-1:0] o_addr_rd,
    output logic                  o_rd_valid,
    output logic                  o_collision
);

    if (!latency_ok(WR_LATENCY)) begin : g_bad_wr
        $fatal(1, "port_latency_stage: WR_LATENCY must be within 1..%0d", MAX_LATENCY);
    end
    if (!latency_ok(RD_LATENCY)) begin : g_bad_rd
        $fatal(1, "port_latency_stage: RD_LATENCY must be within 1..%0d", MAX_LATENCY);
    end
    if (ADDR_WIDTH < $clog2(MEM_DEPTH)) begin : g_bad_aw
        $fatal(1, "port_latency_stage: ADDR_WIDTH too narrow for MEM_DEPTH");
    end

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] addr;
    } wr_req_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
    } rd_req_t;

    wr_req_t wr_in, wr_out;
    rd_req_t rd_in, rd_out;
    logic    tag_out;

    // Accept logic: a non-accepting cycle injects an all-zero bubble.
    always_comb begin
        wr_in = '0;
        rd_in = '0;
        if (i_en && i_we) begin
            wr_in.valid = 1'b1;
            wr_in.data  = i_din;
            wr_in.addr  = i_addr;
        end
        if (i_en && i_rd) begin
            rd_in.valid = 1'b1;
            rd_in.addr  = i_addr;
        end
    end

    delay_line #(.WIDTH($bits(wr_req_t)), .DEPTH(WR_LATENCY)) u_wr_line (
        .clka (clka),
        .rst  (rst),
        .din  (wr_in),
        .dout (wr_out)
    );

    delay_line #(.WIDTH($bits(rd_req_t)), .DEPTH(RD_LATENCY)) u_rd_line (
        .clka (clka),
        .rst  (rst),
        .din  (rd_in),
        .dout (rd_out)
    );

    // Extra stage covers the memory's one-cycle registered read.
    delay_line #(.WIDTH(1), .DEPTH(RD_LATENCY + 1)) u_tag_line (
        .clka (clka),
        .rst  (rst),
        .din  (rd_in.valid),
        .dout (tag_out)
    );

    assign o_en_wr    = wr_out.valid;
    assign o_we       = wr_out.valid;
    assign o_din      = wr_out.data;
    assign o_addr_wr  = wr_out.addr;
    assign o_en_rd    = rd_out.valid;
    assign o_rd_n     = ~rd_out.valid;
    assign o_addr_rd  = rd_out.addr;
    assign o_rd_valid = tag_out;

    // Flag a write and read hitting the same address at the memory this cycle;
    // the memory returns the old data, so this is purely informational.
    always_ff @(posedge clka) begin
        if (rst) begin
            o_collision <= 1'b0;
        end else begin
            o_collision <= wr_out.valid && rd_out.valid && (wr_out.addr == rd_out.addr);
        end
    end

endmodule

// File: tb/tb_port_latency_stage.sv
// Bench for port_latency_stage: a small dual-port memory hangs off the DUT
// outputs, and a history-based reference model predicts every output from
// the log of accepted requests and reset edges.
module tb_port_latency_stage;

    localparam int WL = 3;
    localparam int RL = 2;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int HN = 1024;

    logic          clka = 1'b0;
    logic          rst, i_en, i_we, i_rd;
    logic [DW-1:0] i_din;
    logic [AW-1:0] i_addr;
    logic          o_en_wr, o_we, o_en_rd, o_rd_n, o_rd_valid, o_collision;
    logic [DW-1:0] o_din;
    logic [AW-1:0] o_addr_wr, o_addr_rd;

    always #5 clka = ~clka;

    port_latency_stage #(
        .DATA_WIDTH(DW), .MEM_DEPTH(16), .ADDR_WIDTH(AW),
        .WR_LATENCY(WL), .RD_LATENCY(RL)
    ) dut (
        .clka(clka), .rst(rst), .i_en(i_en), .i_we(i_we), .i_rd(i_rd),
        .i_din(i_din), .i_addr(i_addr),
        .o_en_wr(o_en_wr), .o_we(o_we), .o_din(o_din), .o_addr_wr(o_addr_wr),
        .o_en_rd(o_en_rd), .o_rd_n(o_rd_n), .o_addr_rd(o_addr_rd),
        .o_rd_valid(o_rd_valid), .o_collision(o_collision)
    );

    // Downstream memory: registered read, old data on same-edge write.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] o_douta;
    always @(posedge clka) begin
        if (o_en_rd && !o_rd_n) o_douta <= mem[o_addr_rd];
        if (o_en_wr && o_we) mem[o_addr_wr] <= o_din;
    end

    // Request history, indexed by edge number.
    bit            rst_e [HN];
    bit            wv_h  [HN];
    logic [DW-1:0] wd_h  [HN];
    logic [AW-1:0] wa_h  [HN];
    bit            rv_h  [HN];
    logic [AW-1:0] ra_h  [HN];
    logic [DW-1:0] refmem [16];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    // Expected outputs after the current edge and after the previous one.
    bit            e_wv, e_rv, e_vld, e_col, p_wv, p_rv;
    logic [DW-1:0] e_wd, p_wd, e_dout;
    logic [AW-1:0] e_wa, e_ra, p_wa, p_ra;

    function automatic bit clean(input int n, input int t);
        for (int k = n + 1; k <= t; k++) if (rst_e[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit en, input bit we, input bit rd,
                        input logic [DW-1:0] din, input logic [AW-1:0] addr, input bit r);
        int n;
        rst = r; i_en = en; i_we = we; i_rd = rd; i_din = din; i_addr = addr;
        @(posedge clka);
        cyc++;
        rst_e[cyc] = r;
        wv_h[cyc] = en && we && !r; wd_h[cyc] = din; wa_h[cyc] = addr;
        rv_h[cyc] = en && rd && !r; ra_h[cyc] = addr;
        // Memory effect at this edge comes from what was presented before it.
        if (p_rv) e_dout = refmem[p_ra];
        if (p_wv) refmem[p_wa] = p_wd;
        e_col = !r && p_wv && p_rv && (p_wa == p_ra);
        n = cyc - WL + 1;
        e_wv = (n >= 1) && wv_h[n] && clean(n, cyc);
        e_wd = e_wv ? wd_h[n] : '0;
        e_wa = e_wv ? wa_h[n] : '0;
        n = cyc - RL + 1;
        e_rv = (n >= 1) && rv_h[n] && clean(n, cyc);
        e_ra = e_rv ? ra_h[n] : '0;
        n = cyc - RL;
        e_vld = (n >= 1) && rv_h[n] && clean(n, cyc);
        @(negedge clka);
        chk("en_wr",     32'(o_en_wr),     32'(e_wv));
        chk("we",        32'(o_we),        32'(e_wv));
        chk("din",       32'(o_din),       32'(e_wd));
        chk("addr_wr",   32'(o_addr_wr),   32'(e_wa));
        chk("en_rd",     32'(o_en_rd),     32'(e_rv));
        chk("rd_n",      32'(o_rd_n),      32'(!e_rv));
        chk("addr_rd",   32'(o_addr_rd),   32'(e_ra));
        chk("rd_valid",  32'(o_rd_valid),  32'(e_vld));
        chk("collision", 32'(o_collision), 32'(e_col));
        if (e_vld) chk("douta", 32'(o_douta), 32'(e_dout));
        p_wv = e_wv; p_wd = e_wd; p_wa = e_wa; p_rv = e_rv; p_ra = e_ra;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        int col_cnt;
        logic [DW-1:0] cap;
        p_wv = 0; p_rv = 0; p_wd = '0; p_wa = '0; p_ra = '0; e_dout = '0;

        // Reset held for three cycles, then quiet cycles with no requests.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 8'hFF, 4'hF, 1);
        idle(4);

        // Preload address k with 0x10+k.
        for (int k = 0; k < 16; k++) step(1, 1, 0, 8'(8'h10 + k), 4'(k), 0);
        idle(WL + 1);

        // Single write, then check the memory after it lands.
        step(1, 1, 0, 8'hA5, 4'd4, 0);
        idle(WL + 1);
        chk("mem4", 32'(mem[4]), 32'h0000_00A5);

        // Back-to-back reads of addresses 1..3.
        for (int k = 1; k <= 3; k++) step(1, 0, 1, '0, 4'(k), 0);
        idle(RL + 2);

        // Write then read of address 7 one cycle later meet at the memory
        // together (WL = RL + 1): one collision pulse and old data returned.
        col_cnt = 0; cap = '0;
        step(1, 1, 0, 8'h77, 4'd7, 0);
        col_cnt += int'(o_collision);
        step(1, 0, 1, '0, 4'd7, 0);
        col_cnt += int'(o_collision);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, '0, '0, 0);
            col_cnt += int'(o_collision);
            if (o_rd_valid) cap = o_douta;
        end
        chk("coll_cnt", 32'(col_cnt), 32'd1);
        chk("coll_old", 32'(cap), 32'h0000_0017);
        chk("mem7", 32'(mem[7]), 32'h0000_0077);

        // Writes in flight flushed by reset: memory at address 9 untouched.
        step(1, 1, 0, 8'hEE, 4'd9, 0);
        step(1, 1, 0, 8'hEF, 4'd9, 0);
        step(1, 1, 1, 8'hEA, 4'd9, 1);
        idle(WL + 3);
        chk("mem9", 32'(mem[9]), 32'h0000_0019);

        // Enable low masks both requests.
        for (int i = 0; i < 5; i++) step(0, 1, 1, 8'h5A, 4'd3, 0);
        idle(RL + 2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                 8'($urandom), 4'($urandom), $urandom_range(0, 39) == 0);
        idle(WL + RL + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
